// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns over a 128-bit state, one column per cycle.
// Optional direct-pass path for the final round: define MIX_COLUMNS_SEQ_BYPASS_EN.

module mix_columns (
    input  logic [31:0] col,
    input  logic        inv_en,
    output logic [31:0] result
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3, t, u, v;

    always_comb begin
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        t  = a0 ^ a1 ^ a2 ^ a3;
        u  = xt(xt(a0 ^ a2));
        v  = xt(xt(a1 ^ a3));
        // Precondition with circulant (05,00,04,00); a following forward pass yields InvMixColumns.
        if (inv_en)
            result = {a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v};
        else
            result = {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2),
                      a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
    end
endmodule

module mix_columns_seq #(
    parameter bit OUT_CLR = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, PRE, FWD, DONE} state_t;

    state_t           state, state_nxt;
    logic [0:3][31:0] work, work_wb;
    logic [1:0]       cnt;
    logic             inv_q;
    logic             bypass;
    logic [31:0]      dp_out;
    logic             dp_inv;

`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    assign bypass = in_bypass;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dp_inv    = (state == PRE) && inv_q;

    mix_columns u_dp (
        .col    (work[cnt]),
        .inv_en (dp_inv),
        .result (dp_out)
    );

    always_comb begin
        work_wb      = work;
        work_wb[cnt] = dp_out;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = bypass ? DONE : (in_inv ? PRE : FWD);
            PRE:  if (cnt == 2'd3) state_nxt = FWD;
            FWD:  if (cnt == 2'd3) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            cnt       <= 2'd0;
            inv_q     <= 1'b0;
            out_state <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work  <= in_state;
                    inv_q <= in_inv & ~bypass;
                    cnt   <= 2'd0;
                    if (bypass) out_state <= in_state;
                end
                PRE, FWD: begin
                    // Counter wraps 3->0 exactly at each phase boundary.
                    work <= work_wb;
                    cnt  <= cnt + 2'd1;
                    if (state == FWD && cnt == 2'd3) out_state <= work_wb;
                end
                DONE: if (out_ready && OUT_CLR) out_state <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: vector table with a scoreboard queue, plus backpressure and reset corner cases.

module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
    logic         in_bypass;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    mix_columns_seq #(.OUT_CLR(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    typedef struct {
        logic [127:0] in_s;
        logic         inv;
        logic [127:0] exp_s;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Called at a negedge with the DUT idle; leaves at a negedge.
    task automatic run_one(input logic [127:0] s, input logic inv, input logic [127:0] exp_s,
                           input int exp_lat, input string nm, input bit dchk,
                           output logic [127:0] got_s);
        int  lat;
        bit  got;
        logic [127:0] e;
        if (dchk) exp_q.push_back(exp_s);
        chk({nm, " in_ready"}, {127'd0, in_ready}, 128'd1);
        in_state = s;
        in_inv   = inv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = ~s;
        in_inv   = ~inv;
        lat = 0;
        got = 1'b0;
        got_s = '0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL %s timeout: out_valid never rose", nm);
            if (dchk) void'(exp_q.pop_front());
            return;
        end
        got_s = out_state;
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        if (dchk) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s: output with empty scoreboard", nm);
            end else begin
                e = exp_q.pop_front();
                chk({nm, " data"}, out_state, e);
            end
        end
        if (out_ready) begin
            @(negedge clk);
            chk({nm, " pulse"}, {127'd0, out_valid}, 128'd0);
            chk({nm, " ready_after"}, {127'd0, in_ready}, 128'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] y, z, r, hold_s;
        int seen;

        vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[2] = '{128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6};
        vecs[3] = '{128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 1'b1, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6};
        vecs[4] = '{128'hc6c6c6c6_db135345_2d26314c_01010101, 1'b0, 128'hc6c6c6c6_8e4da1bc_4d7ebdf8_01010101};
        vecs[5] = '{128'hc6c6c6c6_8e4da1bc_4d7ebdf8_01010101, 1'b1, 128'hc6c6c6c6_db135345_2d26314c_01010101};
        vecs[6] = '{128'h0, 1'b0, 128'h0};
        vecs[7] = '{128'h0, 1'b1, 128'h0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        in_inv = 1'b0;
        out_ready = 1'b1;
`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
        in_bypass = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst busy", {127'd0, busy}, 128'd0);
        chk("rst out_state", out_state, 128'd0);

        for (int i = 0; i < 8; i++)
            run_one(vecs[i].in_s, vecs[i].inv, vecs[i].exp_s, vecs[i].inv ? 9 : 5,
                    $sformatf("vec%0d", i), 1'b1, y);

        // Forward then inverse of random states must round-trip.
        for (int k = 0; k < 3; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            run_one(r, 1'b0, '0, 5, "rt_fwd", 1'b0, y);
            run_one(y, 1'b1, r, 9, "rt_inv", 1'b1, z);
        end

        // Backpressure with a lockout attempt during the hold.
        out_ready = 1'b0;
        run_one(vecs[2].in_s, 1'b0, vecs[2].exp_s, 5, "bp", 1'b1, y);
        hold_s = vecs[2].exp_s;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = vecs[0].in_s;
            in_inv   = 1'b0;
            @(negedge clk);
            chk("bp hold valid", {127'd0, out_valid}, 128'd1);
            chk("bp hold data", out_state, hold_s);
            chk("bp lockout", {127'd0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", {127'd0, in_ready}, 128'd1);
        chk("bp release out_valid", {127'd0, out_valid}, 128'd0);
        chk("bp release busy", {127'd0, busy}, 128'd0);
        chk("bp out_state kept", out_state, hold_s);

        // Reset two cycles into the PRE phase of an inverse request.
        in_state = vecs[1].in_s;
        in_inv   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", {127'd0, in_ready}, 128'd1);
        chk("midrst out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst busy", {127'd0, busy}, 128'd0);
        chk("midrst out_state", out_state, 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst no output", 128'(seen), 128'd0);
        run_one(vecs[0].in_s, 1'b0, vecs[0].exp_s, 5, "post_rst", 1'b1, y);

        // Reset coincident with a request: the request is dropped.
        rst = 1'b1;
        in_valid = 1'b1;
        in_state = vecs[0].in_s;
        in_inv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_req busy", {127'd0, busy}, 128'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_req no output", 128'(seen), 128'd0);

`ifdef MIX_COLUMNS_SEQ_BYPASS_EN
        in_bypass = 1'b1;
        run_one(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                128'h00112233_44556677_8899aabb_ccddeeff, 1, "bypass", 1'b1, y);
        in_bypass = 1'b0;
        run_one(vecs[3].in_s, 1'b1, vecs[3].exp_s, 9, "after_bypass", 1'b1, y);
`endif

        chk("scoreboard drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
